// File: rtl/mc_control.sv
// Multi-cycle control FSM for a small MIPS subset (addu, subu, ori, lui, lw, sw, beq, j).
// Moore outputs from the current state; only PCWr in BRANCH follows the live zero flag.
module mc_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               PCWr,
    output logic               IRWr,
    output logic               RegWr,
    output logic               MemWr,
    output logic [1:0]         ALUOp,
    output logic               ALUSrcB,
    output logic [1:0]         ExtOp,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic [1:0]         NPCOp,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 'd0,
        DECODE  = 'd1,
        MEM_ADR = 'd2,
        MEM_RD  = 'd3,
        MEM_WB  = 'd4,
        MEM_WR  = 'd5,
        EXEC_R  = 'd6,
        R_WB    = 'd7,
        EXEC_I  = 'd8,
        I_WB    = 'd9,
        BRANCH  = 'd10,
        JUMP    = 'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HI   = 2'b10;
    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;

    // Plain vector for the register so undefined codes 12-15 are representable.
    logic [STATE_W-1:0] state_q;
    state_e             state_d;

    logic is_rtype, is_itype, is_mem, is_beq, is_j, is_lui;
    logic [1:0] r_alu;

    always_comb begin
        is_rtype = (op == OP_RTYPE) && ((funct == FN_ADDU) || (funct == FN_SUBU));
        is_itype = (op == OP_ORI) || (op == OP_LUI);
        is_mem   = (op == OP_LW) || (op == OP_SW);
        is_beq   = (op == OP_BEQ);
        is_j     = (op == OP_J);
        is_lui   = (op == OP_LUI);
        r_alu    = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Anything without an explicit successor, including unused codes, restarts at FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                if (is_rtype)      state_d = EXEC_R;
                else if (is_itype) state_d = EXEC_I;
                else if (is_mem)   state_d = MEM_ADR;
                else if (is_beq)   state_d = BRANCH;
                else if (is_j)     state_d = JUMP;
                else               state_d = FETCH;
            end
            MEM_ADR: state_d = (op == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:  state_d = MEM_WB;
            EXEC_R:  state_d = R_WB;
            EXEC_I:  state_d = I_WB;
            default: state_d = FETCH;
        endcase
    end

    logic pc_wr, ir_wr, reg_wr, mem_wr;

    always_comb begin
        pc_wr    = 1'b0;
        ir_wr    = 1'b0;
        reg_wr   = 1'b0;
        mem_wr   = 1'b0;
        ALUOp    = ALU_ADD;
        ALUSrcB  = 1'b0;
        ExtOp    = EXT_ZERO;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        NPCOp    = NPC_SEQ;
        case (state_q)
            FETCH: begin
                ir_wr = 1'b1;
                pc_wr = 1'b1;
            end
            EXEC_R: begin
                ALUOp = r_alu;
            end
            R_WB: begin
                ALUOp  = r_alu;
                reg_wr = 1'b1;
                RegDst = 1'b1;
            end
            EXEC_I: begin
                ALUSrcB = 1'b1;
                ALUOp   = ALU_OR;
                ExtOp   = is_lui ? EXT_HI : EXT_ZERO;
            end
            I_WB: begin
                ALUSrcB = 1'b1;
                ALUOp   = ALU_OR;
                ExtOp   = is_lui ? EXT_HI : EXT_ZERO;
                reg_wr  = 1'b1;
            end
            MEM_ADR, MEM_RD: begin
                ALUSrcB = 1'b1;
                ExtOp   = EXT_SIGN;
            end
            MEM_WB: begin
                ALUSrcB  = 1'b1;
                ExtOp    = EXT_SIGN;
                reg_wr   = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WR: begin
                ALUSrcB = 1'b1;
                ExtOp   = EXT_SIGN;
                mem_wr  = 1'b1;
            end
            BRANCH: begin
                ALUOp = ALU_SUB;
                ExtOp = EXT_SIGN;
                NPCOp = NPC_BR;
                pc_wr = zero;
            end
            JUMP: begin
                NPCOp = NPC_JMP;
                pc_wr = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are killed by reset combinationally, not just via the state flop.
    assign PCWr  = pc_wr  & reset;
    assign IRWr  = ir_wr  & reset;
    assign RegWr = reg_wr & reset;
    assign MemWr = mem_wr & reset;
    assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized instruction stream against an instruction-level reference model of the
// control sequence; also covers reset mid-instruction and an unused state code.
module tb_mc_control;

    logic       clk, reset, zero;
    logic [5:0] op, funct;
    logic       PCWr, IRWr, RegWr, MemWr, ALUSrcB, RegDst, MemtoReg;
    logic [1:0] ALUOp, ExtOp, NPCOp;
    logic [3:0] state;
    logic [12:0] ov;

    mc_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
        .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .NPCOp(NPCOp), .state(state)
    );

    assign ov = {PCWr, IRWr, RegWr, MemWr, ALUOp, ALUSrcB, ExtOp, RegDst, MemtoReg, NPCOp};

    always #5 clk = ~clk;

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
    localparam int K_SW = 5, K_BEQ = 6, K_J = 7, K_ILL = 8;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Instruction-level model: cycles and per-cycle control word for each class.
    function automatic int exp_len(input int k);
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI, K_SW: return 4;
            K_LW:                               return 5;
            K_BEQ, K_J:                         return 3;
            default:                            return 2;
        endcase
    endfunction

    function automatic int exp_state(input int k, input int s);
        if (s < 2) return s;
        case (k)
            K_ADDU, K_SUBU: return (s == 2) ? 6 : 7;
            K_ORI, K_LUI:   return (s == 2) ? 8 : 9;
            K_LW:           return s;
            K_SW:           return (s == 2) ? 2 : 5;
            K_BEQ:          return 10;
            K_J:            return 11;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [12:0] exp_vec(input int k, input int s, input logic z);
        logic pc, ir, rw, mw, srcb, rd, m2r;
        logic [1:0] alu, ext, npc;
        pc = 0; ir = 0; rw = 0; mw = 0; srcb = 0; rd = 0; m2r = 0;
        alu = 0; ext = 0; npc = 0;
        if (s == 0) begin
            pc = 1; ir = 1;
        end else if (s >= 2) begin
            case (k)
                K_ADDU, K_SUBU: begin
                    alu = (k == K_SUBU) ? 2'd1 : 2'd0;
                    if (s == 3) begin rw = 1; rd = 1; end
                end
                K_ORI, K_LUI: begin
                    srcb = 1; alu = 2'd2; ext = (k == K_LUI) ? 2'd2 : 2'd0;
                    if (s == 3) rw = 1;
                end
                K_LW, K_SW: begin
                    srcb = 1; ext = 2'd1;
                    if (k == K_LW && s == 4) begin rw = 1; m2r = 1; end
                    if (k == K_SW && s == 3) mw = 1;
                end
                K_BEQ: begin alu = 2'd1; ext = 2'd1; npc = 2'd1; pc = z; end
                K_J:   begin npc = 2'd2; pc = 1; end
                default: ;
            endcase
        end
        return {pc, ir, rw, mw, alu, srcb, ext, rd, m2r, npc};
    endfunction

    function automatic bit legal_op(input logic [5:0] o);
        return o == 6'h00 || o == 6'h0D || o == 6'h0F || o == 6'h23 ||
               o == 6'h2B || o == 6'h04 || o == 6'h02;
    endfunction

    task automatic pick(input int k, output logic [5:0] o, output logic [5:0] f);
        f = 6'($urandom);
        case (k)
            K_ADDU: begin o = 6'h00; f = 6'h21; end
            K_SUBU: begin o = 6'h00; f = 6'h23; end
            K_ORI:  o = 6'h0D;
            K_LUI:  o = 6'h0F;
            K_LW:   o = 6'h23;
            K_SW:   o = 6'h2B;
            K_BEQ:  o = 6'h04;
            K_J:    o = 6'h02;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    o = 6'h00;
                    while (f == 6'h21 || f == 6'h23) f = 6'($urandom);
                end else begin
                    o = 6'($urandom);
                    while (legal_op(o)) o = 6'($urandom);
                end
            end
        endcase
    endtask

    // mode 0: normal; 1: replace the last cycle with a forced unused code 13;
    // 2: pulse reset during step 3 (MEM_RD for lw).
    task automatic run_instr(input int k, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int mode);
        int nrw, nmw, len;
        nrw = 0; nmw = 0; len = exp_len(k);
        op = o; funct = f; zero = z;
        #1;
        for (int s = 0; s < len; s++) begin
            if (mode == 1 && s == len - 1) begin
                force dut.state_q = 4'd13;
                #1;
                chk("forced_state", 32'(state), 32'd13);
                chk("forced_out", 32'(ov), 32'd0);
                release dut.state_q;
                @(posedge clk); @(negedge clk); #1;
                chk("after_13", 32'(state), 32'd0);
                return;
            end
            chk($sformatf("st k%0d s%0d", k, s), 32'(state), 32'(exp_state(k, s)));
            chk($sformatf("out k%0d s%0d", k, s), 32'(ov), 32'(exp_vec(k, s, z)));
            if (mode == 2 && s == 3) begin
                #2 reset = 0;
                #1;
                chk("rst_state", 32'(state), 32'd0);
                chk("rst_strobes", 32'({PCWr, IRWr, RegWr, MemWr}), 32'd0);
                @(posedge clk); #1;
                chk("rst_hold_state", 32'(state), 32'd0);
                chk("rst_hold_strobes", 32'({PCWr, IRWr, RegWr, MemWr}), 32'd0);
                @(negedge clk);
                reset = 1;
                return;
            end
            nrw += int'(RegWr);
            nmw += int'(MemWr);
            @(posedge clk); @(negedge clk);
        end
        chk($sformatf("regwr_cnt k%0d", k), 32'(nrw),
            (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI || k == K_LW) ? 32'd1 : 32'd0);
        chk($sformatf("memwr_cnt k%0d", k), 32'(nmw), (k == K_SW) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [5:0] o, f;
        int k;
        clk = 0; reset = 1; op = 0; funct = 0; zero = 0;
        #1 reset = 0;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_strobes", 32'({PCWr, IRWr, RegWr, MemWr}), 32'd0);
        @(posedge clk); #1;
        chk("reset_hold_strobes", 32'({PCWr, IRWr, RegWr, MemWr}), 32'd0);
        @(negedge clk);
        reset = 1;

        run_instr(K_ADDU, 6'h00, 6'h21, 1'b0, 0);
        run_instr(K_LW,   6'h23, 6'h05, 1'b0, 0);
        run_instr(K_BEQ,  6'h04, 6'h00, 1'b1, 0);
        run_instr(K_BEQ,  6'h04, 6'h00, 1'b0, 0);
        run_instr(K_LUI,  6'h0F, 6'h3F, 1'b1, 0);
        run_instr(K_SW,   6'h2B, 6'h00, 1'b0, 0);
        run_instr(K_ORI,  6'h0D, 6'h21, 1'b0, 0);
        run_instr(K_SUBU, 6'h00, 6'h23, 1'b1, 0);
        run_instr(K_J,    6'h02, 6'h00, 1'b0, 0);
        run_instr(K_ILL,  6'h3F, 6'h00, 1'b0, 0);
        run_instr(K_ILL,  6'h00, 6'h20, 1'b0, 0);
        run_instr(K_J,    6'h02, 6'h00, 1'b0, 1);
        run_instr(K_LW,   6'h23, 6'h00, 1'b0, 2);
        run_instr(K_ADDU, 6'h00, 6'h21, 1'b0, 0);

        for (int i = 0; i < 80; i++) begin
            k = int'($urandom_range(0, 8));
            pick(k, o, f);
            run_instr(k, o, f, 1'($urandom), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=finish", n_chk);
        $fatal(1);
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter STATE_W, default 4, SHALL set the width of the state register and of the state debug output.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 op  input  6  SHALL carry instruction opcode IR[31:26].
REQ-005 funct  input  6  SHALL carry instruction function field IR[5:0].
REQ-006 zero  input  1  SHALL carry the ALU equality flag (result==0).
REQ-007 PCWr  output  1  SHALL be the PC write enable.
REQ-008 IRWr  output  1  SHALL be the IR write enable.
REQ-009 RegWr  output  1  SHALL be the register-file write enable.
REQ-010 MemWr  output  1  SHALL be the data-memory write enable.
REQ-011 ALUOp  output  2  SHALL drive the ALU: 00 add, 01 sub, 10 or, 11 zero.
REQ-012 ALUSrcB  output  1  SHALL select the ALU B operand: 0 register B, 1 extended immediate.
REQ-013 ExtOp  output  2  SHALL select immediate extension: 00 zero-extend, 01 sign-extend, 10 imm<<16.
REQ-014 RegDst  output  1  SHALL select the write register: 0 rt, 1 rd.
REQ-015 MemtoReg  output  1  SHALL select the write-back source: 0 ALUOut, 1 memory data register.
REQ-016 NPCOp  output  2  SHALL select the next PC: 00 PC+4, 01 branch target, 10 jump target.
REQ-017 state  output  STATE_W  SHALL expose the current state code for debug.

Function
REQ-018 The block SHALL be a multi-cycle FSM with these codes: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11.
REQ-019 Transitions SHALL be as follows.
- FETCH->DECODE unconditionally.
- DECODE by op: 000000 with funct 100001 or 100011 ->EXEC_R; 001101 or 001111 ->EXEC_I; 100011 or 101011 ->MEM_ADR; 000100 ->BRANCH; 000010 ->JUMP.
- MEM_ADR: ->MEM_RD if op=100011, else ->MEM_WR.
- MEM_RD->MEM_WB.
- EXEC_R->R_WB.
- EXEC_I->I_WB.
- MEM_WB, MEM_WR, R_WB, I_WB, BRANCH and JUMP ->FETCH.
REQ-020 Illegal op, or R-type with an unsupported funct, SHALL take DECODE->FETCH with no write strobe asserted; the instruction is a no-op.
REQ-021 Unused state codes 12-15 SHALL go to FETCH on the next edge, with all write strobes 0 while in them.
REQ-022 Outputs SHALL be decoded from the current state only (Moore), except PCWr in BRANCH, which SHALL equal zero.
REQ-023 FETCH SHALL drive IRWr=1, PCWr=1, NPCOp=00, ALUOp=00.
REQ-024 EXEC_R SHALL drive ALUSrcB=0, with ALUOp=00 for funct 100001 and ALUOp=01 for funct 100011.
REQ-025 R_WB SHALL drive RegWr=1, RegDst=1, MemtoReg=0, and SHALL hold the EXEC_R ALUOp.
REQ-026 EXEC_I and I_WB SHALL drive ALUSrcB=1, ALUOp=10, and ExtOp=00 for op 001101 or ExtOp=10 for op 001111. I_WB SHALL additionally drive RegWr=1, RegDst=0, MemtoReg=0.
REQ-027 MEM_ADR, MEM_RD, MEM_WB and MEM_WR SHALL drive ALUSrcB=1, ExtOp=01, ALUOp=00.
- MEM_WR: MemWr=1.
- MEM_WB: RegWr=1, RegDst=0, MemtoReg=1.
REQ-028 BRANCH SHALL drive ALUSrcB=0, ALUOp=01, ExtOp=01, NPCOp=01, PCWr=zero.
REQ-029 JUMP SHALL drive NPCOp=10, PCWr=1.
REQ-030 Every output not listed for a state SHALL be 0.
REQ-031 Cycles per instruction SHALL be:
- addu, subu, ori, lui, sw: 4
- lw: 5
- beq, j: 3
- illegal: 2
REQ-032 At most one of RegWr and MemWr SHALL be 1 in any cycle, and each write strobe SHALL be high for at most one cycle per instruction.
REQ-033 op and funct SHALL be sampled from IR, which is stable after FETCH; the block holds no instruction copy.

Reset
REQ-034 When reset is 0, the state SHALL become FETCH immediately (asynchronously), and PCWr, IRWr, RegWr and MemWr SHALL be forced to 0 combinationally for as long as reset is 0.
REQ-035 Reset asserted mid-instruction SHALL abandon the instruction with no further write strobe.
REQ-036 The first rising edge after reset deasserts SHALL perform a FETCH (PCWr=1, IRWr=1), then move to DECODE.

Verification
REQ-037 Reset release then addu (op=000000, funct=100001): state sequence 0,1,6,7,0; RegWr=1 only in state 7, with RegDst=1 and ALUOp=00.
REQ-038 lw (op=100011): sequence 0,1,2,3,4,0; MEM_WB drives RegWr=1, MemtoReg=1; ExtOp=01 throughout MEM_ADR..MEM_WB.
REQ-039 beq (op=000100) with zero=1, then again with zero=0: PCWr=1 in BRANCH for the first and PCWr=0 for the second; NPCOp=01 both times; 3 cycles each.
REQ-040 lui (op=001111): ExtOp=10, ALUOp=10 and RegWr=1 in I_WB. sw (op=101011): MemWr=1 for exactly 1 cycle and RegWr never asserted.
REQ-041 op=111111: sequence 0,1,0 with all write strobes 0 in DECODE. Force state code 13: the next state is 0.
REQ-042 reset pulsed low during MEM_RD: state reads 0 immediately; no RegWr occurs; fetch resumes on the first edge after release.
